// File: rtl/cfg_ctx_dispatcher.sv
// Purpose: holds N_CTX stream-configuration contexts; on an accepted request, latches one and fans decoded fields to ROU/ACT/IV/BA.
// Latency: ROU fields 1 cycle after accept; ACT/IV/BA after 1+*_DELAY; done_o pulses at 1+MAX_DELAY.
// Backpressure: ctx_ready_o is low while busy (except the done cycle) and during flush; the requester must hold ctx_valid_i.
module cfg_ctx_dispatcher #(
  parameter int N_STREAMS       = 4,
  parameter int N_CTX           = 4,
  parameter int ACT_DELAY       = 1,
  parameter int IV_DELAY        = 2,
  parameter int BA_DELAY        = 3,
  parameter int NBIT_HWLP_SEL   = 2,
  parameter int NBIT_IV_SEL     = 2,
  parameter int NBIT_IV_CONST   = 8,
  parameter int NBIT_N_BANKS    = 3,
  parameter int NBIT_BLOCK_SIZE = 4,
  parameter int NBIT_STREAM_LNS = 4,
  // Stream word layout, LSB first; each N_END_* is the exclusive end of its field.
  localparam int N_END_VALID = 1,
  localparam int N_END_ACC   = N_END_VALID + 1,
  localparam int N_END_HWLP  = N_END_ACC + NBIT_HWLP_SEL,
  localparam int N_END_IVSEL = N_END_HWLP + NBIT_IV_SEL,
  localparam int N_END_IVC   = N_END_IVSEL + NBIT_IV_CONST,
  localparam int N_END_NB    = N_END_IVC + NBIT_N_BANKS,
  localparam int N_END_SB    = N_END_NB + NBIT_N_BANKS,
  localparam int N_END_BS    = N_END_SB + NBIT_BLOCK_SIZE,
  localparam int N_END_LNS   = N_END_BS + NBIT_STREAM_LNS,
  localparam int NBIT_CFG_STREAM_WORD = N_END_LNS,
  // One extra index bit so that out-of-range ids are representable and reach the error check.
  localparam int CTX_W = $clog2(N_CTX) + 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [N_CTX*N_STREAMS*NBIT_CFG_STREAM_WORD-1:0] cfgmem_content_i,
  input  logic                                        ctx_valid_i,
  output logic                                        ctx_ready_o,
  input  logic [CTX_W-1:0]                            ctx_id_i,
  input  logic [N_STREAMS-1:0]                        stream_mask_i,
  input  logic                                        flush_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        ctx_err_o,
  output logic [N_STREAMS*NBIT_HWLP_SEL-1:0]          hwlp_sel_o,
  output logic [N_STREAMS*NBIT_IV_SEL-1:0]            iv_constraint_sel_o,
  output logic [N_STREAMS-1:0]                        is_acc_store_rou_o,
  output logic [N_STREAMS-1:0]                        is_age_active_rou_o,
  output logic [N_STREAMS-1:0]                        is_age_active_o,
  output logic [N_STREAMS*NBIT_IV_CONST-1:0]          const_iv_o,
  output logic [N_STREAMS*NBIT_N_BANKS-1:0]           n_banks_o,
  output logic [N_STREAMS*NBIT_N_BANKS-1:0]           start_banks_o,
  output logic [N_STREAMS*NBIT_BLOCK_SIZE-1:0]        block_size_o,
  output logic [N_STREAMS*NBIT_STREAM_LNS-1:0]        stream_lns_o,
  output logic [N_STREAMS-1:0]                        is_acc_store_o
);

  localparam int MAX_AI    = (ACT_DELAY > IV_DELAY) ? ACT_DELAY : IV_DELAY;
  localparam int MAX_DELAY = (MAX_AI > BA_DELAY) ? MAX_AI : BA_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int SW        = NBIT_CFG_STREAM_WORD;
  localparam int CTX_BITS  = N_STREAMS * SW;
  localparam int IV_BITS   = N_STREAMS * NBIT_IV_CONST;
  // BA group word per stream: {is_acc_store, stream_lns, block_size, start_banks, n_banks}
  localparam int BA_W      = 2 * NBIT_N_BANKS + NBIT_BLOCK_SIZE + NBIT_STREAM_LNS + 1;
  localparam int BA_BITS   = N_STREAMS * BA_W;
  localparam int OFF_SB    = NBIT_N_BANKS;
  localparam int OFF_BS    = 2 * NBIT_N_BANKS;
  localparam int OFF_LNS   = OFF_BS + NBIT_BLOCK_SIZE;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CTX_BITS-1:0]    cfg_q, cfg_d;
  logic [N_STREAMS-1:0]   mask_q, mask_d;
  logic                   err_q, err_d;

  logic [ACT_DELAY-1:0][N_STREAMS-1:0] act_pipe_q, act_pipe_d;
  logic [IV_DELAY-1:0][IV_BITS-1:0]    iv_pipe_q, iv_pipe_d;
  logic [BA_DELAY-1:0][BA_BITS-1:0]    ba_pipe_q, ba_pipe_d;

  logic [CTX_BITS-1:0]    cfg_sel;
  logic [SW-1:0]          word;
  logic [BA_W-1:0]        ba_word;
  logic [N_STREAMS-1:0]   dec_act, dec_acc;
  logic [IV_BITS-1:0]     dec_iv;
  logic [BA_BITS-1:0]     dec_ba;
  logic                   ctx_ok, done, ready, accept;

  // Context selection from the flat context memory by index.
  always_comb begin
    cfg_sel = '0;
    ctx_ok  = (ctx_id_i < CTX_W'(N_CTX));
    for (int c = 0; c < N_CTX; c++) begin
      if (ctx_id_i == CTX_W'(c)) cfg_sel = cfgmem_content_i[c*CTX_BITS +: CTX_BITS];
    end
  end

  // Decode latched context; masked streams lose valid and is_acc_store only.
  always_comb begin
    word                = '0;
    dec_act             = '0;
    dec_acc             = '0;
    dec_iv              = '0;
    dec_ba              = '0;
    hwlp_sel_o          = '0;
    iv_constraint_sel_o = '0;
    for (int s = 0; s < N_STREAMS; s++) begin
      word       = cfg_q[s*SW +: SW];
      dec_act[s] = word[0] & mask_q[s];
      dec_acc[s] = word[N_END_VALID] & mask_q[s];
      hwlp_sel_o[s*NBIT_HWLP_SEL +: NBIT_HWLP_SEL]        = word[N_END_ACC +: NBIT_HWLP_SEL];
      iv_constraint_sel_o[s*NBIT_IV_SEL +: NBIT_IV_SEL]   = word[N_END_HWLP +: NBIT_IV_SEL];
      dec_iv[s*NBIT_IV_CONST +: NBIT_IV_CONST]            = word[N_END_IVSEL +: NBIT_IV_CONST];
      dec_ba[s*BA_W +: BA_W] = {dec_acc[s],
                                word[N_END_BS +: NBIT_STREAM_LNS],
                                word[N_END_SB +: NBIT_BLOCK_SIZE],
                                word[N_END_NB +: NBIT_N_BANKS],
                                word[N_END_IVC +: NBIT_N_BANKS]};
    end
  end

  assign is_age_active_rou_o = dec_act;
  assign is_acc_store_rou_o  = dec_acc;

  // Control FSM: accept, error pulse, settle counter, flush override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    // The done cycle already counts as free so back-to-back loads lose no cycle.
    done    = (state_q == S_BUSY) && (cnt_q == '0) && !flush_i;
    ready   = ((state_q == S_IDLE) || done) && !flush_i;
    accept  = ctx_valid_i && ready;
    if (state_q == S_BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      if (done) state_d = S_IDLE;
    end
    if (accept) begin
      if (ctx_ok) begin
        cfg_d   = cfg_sel;
        mask_d  = stream_mask_i;
        state_d = S_BUSY;
        cnt_d   = CNT_W'(MAX_DELAY);
      end else begin
        err_d   = 1'b1;
      end
    end
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cfg_d   = '0;
      mask_d  = '0;
      err_d   = 1'b0;
    end
  end

  // Group pipelines shift every cycle from the decode; each group is one bus so fields never mix contexts.
  always_comb begin
    act_pipe_d    = act_pipe_q;
    iv_pipe_d     = iv_pipe_q;
    ba_pipe_d     = ba_pipe_q;
    act_pipe_d[0] = dec_act;
    iv_pipe_d[0]  = dec_iv;
    ba_pipe_d[0]  = dec_ba;
    for (int i = 1; i < ACT_DELAY; i++) act_pipe_d[i] = act_pipe_q[i-1];
    for (int i = 1; i < IV_DELAY; i++)  iv_pipe_d[i]  = iv_pipe_q[i-1];
    for (int i = 1; i < BA_DELAY; i++)  ba_pipe_d[i]  = ba_pipe_q[i-1];
    if (flush_i) begin
      act_pipe_d = '0;
      iv_pipe_d  = '0;
      ba_pipe_d  = '0;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      act_pipe_q <= '0;
      iv_pipe_q  <= '0;
      ba_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      act_pipe_q <= act_pipe_d;
      iv_pipe_q  <= iv_pipe_d;
      ba_pipe_q  <= ba_pipe_d;
    end
  end

  // Unpack the last BA stage into its per-field output buses.
  always_comb begin
    ba_word        = '0;
    n_banks_o      = '0;
    start_banks_o  = '0;
    block_size_o   = '0;
    stream_lns_o   = '0;
    is_acc_store_o = '0;
    for (int s = 0; s < N_STREAMS; s++) begin
      ba_word = ba_pipe_q[BA_DELAY-1][s*BA_W +: BA_W];
      n_banks_o[s*NBIT_N_BANKS +: NBIT_N_BANKS]         = ba_word[0 +: NBIT_N_BANKS];
      start_banks_o[s*NBIT_N_BANKS +: NBIT_N_BANKS]     = ba_word[OFF_SB +: NBIT_N_BANKS];
      block_size_o[s*NBIT_BLOCK_SIZE +: NBIT_BLOCK_SIZE] = ba_word[OFF_BS +: NBIT_BLOCK_SIZE];
      stream_lns_o[s*NBIT_STREAM_LNS +: NBIT_STREAM_LNS] = ba_word[OFF_LNS +: NBIT_STREAM_LNS];
      is_acc_store_o[s] = ba_word[BA_W-1];
    end
  end

  assign is_age_active_o = act_pipe_q[ACT_DELAY-1];
  assign const_iv_o      = iv_pipe_q[IV_DELAY-1];
  assign ctx_ready_o     = ready;
  assign busy_o          = (state_q == S_BUSY);
  assign done_o          = done;
  assign ctx_err_o       = err_q;

endmodule
